// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types for the functional-unit writeback arbiter.
// Widths come from `GPR_SIZE / `ROB_IDX_SIZE; defaults apply only if the build has not set them.
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

package fu_wb_arbiter_pkg;

  typedef logic [3:0] nzcv_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LS  = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic [`ROB_IDX_SIZE-1:0] dst_rob_index;
    logic [`GPR_SIZE-1:0]     value;
    logic                     set_nzcv;
    nzcv_t                    nzcv;
  } wb_entry_t;

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// Writeback bus between the ALU/LS units, the arbiter and the ROB.
// master = functional-unit/ROB side, slave = arbiter.
interface fu_wb_arbiter_if;
  import fu_wb_arbiter_pkg::*;

  logic                     in_alu_done;
  logic [`ROB_IDX_SIZE-1:0] in_alu_dst_rob_index;
  logic [`GPR_SIZE-1:0]     in_alu_value;
  logic                     in_alu_set_nzcv;
  nzcv_t                    in_alu_nzcv;
  logic                     in_ls_done;
  logic [`ROB_IDX_SIZE-1:0] in_ls_dst_rob_index;
  logic [`GPR_SIZE-1:0]     in_ls_value;
  logic                     in_rob_stall;

  logic                     out_alu_ready;
  logic                     out_ls_ready;
  logic                     out_rob_done;
  logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic [`GPR_SIZE-1:0]     out_rob_value;
  logic                     out_rob_set_nzcv;
  nzcv_t                    out_rob_nzcv;
  wb_src_t                  out_rob_src;

  modport master (
    output in_alu_done, in_alu_dst_rob_index, in_alu_value, in_alu_set_nzcv, in_alu_nzcv,
    output in_ls_done, in_ls_dst_rob_index, in_ls_value, in_rob_stall,
    input  out_alu_ready, out_ls_ready, out_rob_done, out_rob_dst_rob_index,
    input  out_rob_value, out_rob_set_nzcv, out_rob_nzcv, out_rob_src
  );

  modport slave (
    input  in_alu_done, in_alu_dst_rob_index, in_alu_value, in_alu_set_nzcv, in_alu_nzcv,
    input  in_ls_done, in_ls_dst_rob_index, in_ls_value, in_rob_stall,
    output out_alu_ready, out_ls_ready, out_rob_done, out_rob_dst_rob_index,
    output out_rob_value, out_rob_set_nzcv, out_rob_nzcv, out_rob_src
  );

endinterface

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a writeback source that lost arbitration or hit a ROB stall.
module wb_hold_buf
  import fu_wb_arbiter_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_load,
  input  logic      i_clear,
  input  wb_entry_t i_entry,
  output logic      o_valid,
  output wb_entry_t o_entry,
  output logic      o_ready
);

  logic      r_valid;
  wb_entry_t r_entry;

  // load and clear never coincide: load needs an empty buffer, clear a full one
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_valid <= 1'b0;
    else if (i_load)  r_valid <= 1'b1;
    else if (i_clear) r_valid <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_load) r_entry <= i_entry;
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;
  assign o_ready = !r_valid;

endmodule

// File: rtl/fu_wb_arbiter.sv
// Arbitrates ALU and LS results onto a single registered ROB writeback port.
// FU_WB_ROUND_ROBIN_EN selects round-robin conflict resolution; otherwise ALU has fixed priority.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
(
  input  logic           in_clk,
  input  logic           in_rst,
  fu_wb_arbiter_if.slave wb
);

  logic      w_alu_buf_vld, w_ls_buf_vld, w_alu_rdy, w_ls_rdy;
  logic      w_alu_acc_p0, w_ls_acc_p0, w_alu_cand_vld_p0, w_ls_cand_vld_p0;
  logic      w_adv_p0, w_gnt_alu_p0, w_gnt_ls_p0;
  wb_entry_t w_alu_in_p0, w_ls_in_p0, w_alu_buf, w_ls_buf, w_alu_cand_p0, w_ls_cand_p0;
  logic      r_vld_p1;
  wb_entry_t r_out_p1;
  wb_src_t   r_src_p1;

  // stage p0: accept, select candidates, arbitrate
  assign w_alu_in_p0 = '{dst_rob_index: wb.in_alu_dst_rob_index, value: wb.in_alu_value,
                         set_nzcv: wb.in_alu_set_nzcv, nzcv: wb.in_alu_nzcv};
  assign w_ls_in_p0  = '{dst_rob_index: wb.in_ls_dst_rob_index, value: wb.in_ls_value,
                         set_nzcv: 1'b0, nzcv: '0};

  assign w_alu_acc_p0      = wb.in_alu_done && w_alu_rdy;
  assign w_ls_acc_p0       = wb.in_ls_done && w_ls_rdy;
  assign w_alu_cand_vld_p0 = w_alu_buf_vld || w_alu_acc_p0;
  assign w_ls_cand_vld_p0  = w_ls_buf_vld || w_ls_acc_p0;
  assign w_alu_cand_p0     = w_alu_buf_vld ? w_alu_buf : w_alu_in_p0;
  assign w_ls_cand_p0      = w_ls_buf_vld ? w_ls_buf : w_ls_in_p0;
  assign w_adv_p0          = !r_vld_p1 || !wb.in_rob_stall;

`ifdef FU_WB_ROUND_ROBIN_EN
  wb_src_t r_last_grant;

  always_ff @(posedge in_clk) begin
    if (in_rst)            r_last_grant <= WB_SRC_LS;
    else if (w_gnt_alu_p0) r_last_grant <= WB_SRC_ALU;
    else if (w_gnt_ls_p0)  r_last_grant <= WB_SRC_LS;
  end
`endif

  always_comb begin
    w_gnt_alu_p0 = 1'b0;
    w_gnt_ls_p0  = 1'b0;
    if (w_adv_p0) begin
      if (w_alu_cand_vld_p0 && w_ls_cand_vld_p0) begin
`ifdef FU_WB_ROUND_ROBIN_EN
        if (r_last_grant == WB_SRC_LS) w_gnt_alu_p0 = 1'b1;
        else                           w_gnt_ls_p0  = 1'b1;
`else
        w_gnt_alu_p0 = 1'b1;
`endif
      end else begin
        w_gnt_alu_p0 = w_alu_cand_vld_p0;
        w_gnt_ls_p0  = w_ls_cand_vld_p0;
      end
    end
  end

  wb_hold_buf u_alu_buf (
    .i_clk   (in_clk),
    .i_rst   (in_rst),
    .i_load  (w_alu_acc_p0 && !w_gnt_alu_p0),
    .i_clear (w_alu_buf_vld && w_gnt_alu_p0),
    .i_entry (w_alu_in_p0),
    .o_valid (w_alu_buf_vld),
    .o_entry (w_alu_buf),
    .o_ready (w_alu_rdy)
  );

  wb_hold_buf u_ls_buf (
    .i_clk   (in_clk),
    .i_rst   (in_rst),
    .i_load  (w_ls_acc_p0 && !w_gnt_ls_p0),
    .i_clear (w_ls_buf_vld && w_gnt_ls_p0),
    .i_entry (w_ls_in_p0),
    .o_valid (w_ls_buf_vld),
    .o_entry (w_ls_buf),
    .o_ready (w_ls_rdy)
  );

  // stage p1: ROB output register, frozen while the ROB stalls a valid result
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_vld_p1 <= 1'b0;
      r_out_p1 <= '0;
      r_src_p1 <= WB_SRC_ALU;
    end else if (w_adv_p0) begin
      r_vld_p1 <= w_gnt_alu_p0 || w_gnt_ls_p0;
      if (w_gnt_alu_p0) begin
        r_out_p1 <= w_alu_cand_p0;
        r_src_p1 <= WB_SRC_ALU;
      end else if (w_gnt_ls_p0) begin
        r_out_p1 <= w_ls_cand_p0;
        r_src_p1 <= WB_SRC_LS;
      end
    end
  end

  assign wb.out_alu_ready         = w_alu_rdy;
  assign wb.out_ls_ready          = w_ls_rdy;
  assign wb.out_rob_done          = r_vld_p1;
  assign wb.out_rob_dst_rob_index = r_out_p1.dst_rob_index;
  assign wb.out_rob_value         = r_out_p1.value;
  assign wb.out_rob_set_nzcv      = r_out_p1.set_nzcv;
  assign wb.out_rob_nzcv          = r_out_p1.nzcv;
  assign wb.out_rob_src           = r_src_p1;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Self-checking bench for fu_wb_arbiter: directed vector table plus scoreboarded streams.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  localparam int IW = `ROB_IDX_SIZE;
  localparam int GW = `GPR_SIZE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fu_wb_arbiter_if wb_if ();
  fu_wb_arbiter dut (.in_clk(clk), .in_rst(rst), .wb(wb_if));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, stall, a_done;
    logic [IW-1:0] a_idx; logic [GW-1:0] a_val; logic a_set; logic [3:0] a_nzcv;
    logic l_done; logic [IW-1:0] l_idx; logic [GW-1:0] l_val;
    logic e_done, e_chk;
    logic [IW-1:0] e_idx; logic [GW-1:0] e_val; logic e_set; logic [3:0] e_nzcv;
    logic e_src, e_ardy, e_lrdy;
  } vec_t;

  function automatic vec_t v(input logic r, s, ad, input int ai, av, input logic as, input int an,
                             input logic ld, input int li, lv,
                             input logic ed, ec, input int ei, ev, input logic es, input int en,
                             input logic esrc, ar, lr);
    vec_t x;
    x.rst = r; x.stall = s; x.a_done = ad; x.a_idx = IW'(ai); x.a_val = GW'(av);
    x.a_set = as; x.a_nzcv = 4'(an); x.l_done = ld; x.l_idx = IW'(li); x.l_val = GW'(lv);
    x.e_done = ed; x.e_chk = ec; x.e_idx = IW'(ei); x.e_val = GW'(ev); x.e_set = es;
    x.e_nzcv = 4'(en); x.e_src = esrc; x.e_ardy = ar; x.e_lrdy = lr;
    return x;
  endfunction

  typedef struct { logic [IW-1:0] idx; logic [GW-1:0] val; logic set; logic [3:0] nzcv; } item_t;
  item_t exp_a_q[$];
  item_t exp_l_q[$];
  logic  log_src[$];

  task automatic drive_idle();
    wb_if.in_alu_done = 1'b0; wb_if.in_alu_dst_rob_index = '0; wb_if.in_alu_value = '0;
    wb_if.in_alu_set_nzcv = 1'b0; wb_if.in_alu_nzcv = '0;
    wb_if.in_ls_done = 1'b0; wb_if.in_ls_dst_rob_index = '0; wb_if.in_ls_value = '0;
    wb_if.in_rob_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // drives na ALU and nl LS results honoring ready; scoreboard checks every consumed output
  task automatic run_stream(input int na, input int nl, input bit rnd, input int limit);
    int ai = 0, li = 0, got = 0, cyc = 0;
    item_t it;
    log_src.delete();
    while (got < na + nl && cyc < limit) begin
      wb_if.in_rob_stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (wb_if.out_rob_done && !wb_if.in_rob_stall) begin
        got++;
        log_src.push_back(wb_if.out_rob_src);
        if (wb_if.out_rob_src == WB_SRC_ALU) begin
          if (exp_a_q.size() == 0) chk("stream_alu_extra", 64'(wb_if.out_rob_dst_rob_index), 64'hFFFF);
          else begin
            it = exp_a_q.pop_front();
            chk("stream_alu_idx", 64'(wb_if.out_rob_dst_rob_index), 64'(it.idx));
            chk("stream_alu_val", 64'(wb_if.out_rob_value), 64'(it.val));
            chk("stream_alu_set", 64'(wb_if.out_rob_set_nzcv), 64'(it.set));
            chk("stream_alu_nzcv", 64'(wb_if.out_rob_nzcv), 64'(it.nzcv));
          end
        end else begin
          if (exp_l_q.size() == 0) chk("stream_ls_extra", 64'(wb_if.out_rob_dst_rob_index), 64'hFFFF);
          else begin
            it = exp_l_q.pop_front();
            chk("stream_ls_idx", 64'(wb_if.out_rob_dst_rob_index), 64'(it.idx));
            chk("stream_ls_val", 64'(wb_if.out_rob_value), 64'(it.val));
            chk("stream_ls_set", 64'(wb_if.out_rob_set_nzcv), 64'd0);
            chk("stream_ls_nzcv", 64'(wb_if.out_rob_nzcv), 64'd0);
          end
        end
      end
      wb_if.in_alu_done = 1'b0;
      if (ai < na && wb_if.out_alu_ready && (!rnd || $urandom_range(0, 4) != 0)) begin
        it.idx = IW'(ai); it.val = GW'(32'hA000_0000 + ai);
        it.set = rnd ? 1'($urandom_range(0, 1)) : 1'(ai % 2); it.nzcv = 4'($urandom_range(0, 15));
        wb_if.in_alu_done = 1'b1; wb_if.in_alu_dst_rob_index = it.idx; wb_if.in_alu_value = it.val;
        wb_if.in_alu_set_nzcv = it.set; wb_if.in_alu_nzcv = it.nzcv;
        exp_a_q.push_back(it); ai++;
      end
      wb_if.in_ls_done = 1'b0;
      if (li < nl && wb_if.out_ls_ready && (!rnd || $urandom_range(0, 4) != 0)) begin
        it.idx = IW'(li + 32); it.val = GW'(32'h5000_0000 + li); it.set = 1'b0; it.nzcv = '0;
        wb_if.in_ls_done = 1'b1; wb_if.in_ls_dst_rob_index = it.idx; wb_if.in_ls_value = it.val;
        exp_l_q.push_back(it); li++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive_idle();
    chk("stream_delivered", 64'(got), 64'(na + nl));
    chk("stream_alu_left", 64'(exp_a_q.size()), 64'd0);
    chk("stream_ls_left", 64'(exp_l_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("stream_drain_done", 64'(wb_if.out_rob_done), 64'd0);
    exp_a_q.delete(); exp_l_q.delete();
  endtask

  vec_t tbl[$];
  logic exp_order[6];

  initial begin
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;

    // rst stall | ALU done idx val set nzcv | LS done idx val | exp done chk idx val set nzcv src ardy lrdy
    tbl.push_back(v(1,0, 0,0,0,0,0,     0,0,0,     0,1,0,0,0,0,0,     1,1)); // reset state
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));
    tbl.push_back(v(0,0, 1,3,42,1,4,    0,0,0,     1,1,3,42,1,4,0,    1,1)); // single ALU
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));
    tbl.push_back(v(1,0, 0,0,0,0,0,     0,0,0,     0,1,0,0,0,0,0,     1,1));
    tbl.push_back(v(0,0, 1,1,10,1,10,   1,2,20,    1,1,1,10,1,10,0,   1,0)); // conflict
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     1,1,2,20,0,0,1,    1,1));
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));
    tbl.push_back(v(0,0, 1,5,55,1,1,    0,0,0,     1,1,5,55,1,1,0,    1,1)); // stall hold
    tbl.push_back(v(0,1, 0,0,0,0,0,     1,6,66,    1,1,5,55,1,1,0,    1,0));
    tbl.push_back(v(0,1, 0,0,0,0,0,     0,0,0,     1,1,5,55,1,1,0,    1,0));
    tbl.push_back(v(0,1, 0,0,0,0,0,     0,0,0,     1,1,5,55,1,1,0,    1,0));
    tbl.push_back(v(0,1, 0,0,0,0,0,     0,0,0,     1,1,5,55,1,1,0,    1,0));
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     1,1,6,66,0,0,1,    1,1));
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));
    tbl.push_back(v(0,0, 1,7,70,0,0,    0,0,0,     1,1,7,70,0,0,0,    1,1)); // reset with full buffers
    tbl.push_back(v(0,1, 1,8,80,1,2,    1,9,90,    1,1,7,70,0,0,0,    0,0));
    tbl.push_back(v(1,1, 1,10,100,1,3,  1,12,120,  0,1,0,0,0,0,0,     1,1));
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));
    tbl.push_back(v(1,0, 1,11,110,1,5,  0,0,0,     0,1,0,0,0,0,0,     1,1)); // input during reset
    tbl.push_back(v(0,0, 0,0,0,0,0,     0,0,0,     0,0,0,0,0,0,0,     1,1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; wb_if.in_rob_stall = tbl[i].stall;
      wb_if.in_alu_done = tbl[i].a_done; wb_if.in_alu_dst_rob_index = tbl[i].a_idx;
      wb_if.in_alu_value = tbl[i].a_val; wb_if.in_alu_set_nzcv = tbl[i].a_set;
      wb_if.in_alu_nzcv = tbl[i].a_nzcv;
      wb_if.in_ls_done = tbl[i].l_done; wb_if.in_ls_dst_rob_index = tbl[i].l_idx;
      wb_if.in_ls_value = tbl[i].l_val;
      @(posedge clk); #1;
      chk($sformatf("row%0d_done", i), 64'(wb_if.out_rob_done), 64'(tbl[i].e_done));
      chk($sformatf("row%0d_alu_ready", i), 64'(wb_if.out_alu_ready), 64'(tbl[i].e_ardy));
      chk($sformatf("row%0d_ls_ready", i), 64'(wb_if.out_ls_ready), 64'(tbl[i].e_lrdy));
      if (tbl[i].e_chk) begin
        chk($sformatf("row%0d_idx", i), 64'(wb_if.out_rob_dst_rob_index), 64'(tbl[i].e_idx));
        chk($sformatf("row%0d_val", i), 64'(wb_if.out_rob_value), 64'(tbl[i].e_val));
        chk($sformatf("row%0d_set", i), 64'(wb_if.out_rob_set_nzcv), 64'(tbl[i].e_set));
        chk($sformatf("row%0d_nzcv", i), 64'(wb_if.out_rob_nzcv), 64'(tbl[i].e_nzcv));
        chk($sformatf("row%0d_src", i), 64'(wb_if.out_rob_src), 64'(tbl[i].e_src));
      end
    end
    rst = 1'b0;
    drive_idle();

    // three back-to-back conflicting pairs: grant order depends on the policy
`ifdef FU_WB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    run_stream(3, 3, 1'b0, 60);
    for (int k = 0; k < 6; k++) begin
      if (k < log_src.size()) chk($sformatf("pairs_src%0d", k), 64'(log_src[k]), 64'(exp_order[k]));
      else chk($sformatf("pairs_missing%0d", k), 64'(log_src.size()), 64'(k + 1));
    end

    do_reset();
    run_stream(100, 100, 1'b1, 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 Parameter-free; widths come from the existing `GPR_SIZE and `ROB_IDX_SIZE macros.
REQ-002 in_clk  input  1  sole clock; all state updates on posedge.
REQ-003 in_rst  input  1  reset, synchronous and active-high.
REQ-004 in_alu_done / in_ls_done  input  1 each  source presents a result this cycle.
REQ-005 in_alu_dst_rob_index / in_ls_dst_rob_index  input  `ROB_IDX_SIZE each  destination ROB slot.
REQ-006 in_alu_value / in_ls_value  input  `GPR_SIZE each  result value.
REQ-007 in_alu_set_nzcv  input  1, and in_alu_nzcv  input  nzcv_t  ALU flag update; LS has no flag inputs.
REQ-008 in_rob_stall  input  1  ROB cannot accept a writeback this cycle.
REQ-009 out_alu_ready / out_ls_ready  output  1 each  source may present a result this cycle.
REQ-010 out_rob_done  output  1; out_rob_dst_rob_index  output  `ROB_IDX_SIZE; out_rob_value  output  `GPR_SIZE; out_rob_set_nzcv  output  1; out_rob_nzcv  output  nzcv_t; out_rob_src  output  wb_src_t.
REQ-011 All out_rob_* ports are driven directly from registers.

Function
REQ-012 Accept: an input is accepted when in_X_done && out_X_ready; out_X_ready = !buf_X_valid, derived from registered state only.
REQ-013 Candidate: for each source, the candidate is its holding buffer if valid, else the accepted input.
REQ-014 Output register: loads when (!out_rob_done || !in_rob_stall), the "advance" condition.
REQ-015 Advance with at least one candidate: load the winner; out_rob_done=1 next cycle.
REQ-016 Advance with no candidate: out_rob_done=0 next cycle.
REQ-017 No advance (out_rob_done && in_rob_stall): all out_rob_* hold their values; no grant is issued.
REQ-018 Any accepted input that is not granted is written into that source's buffer (capacity 1).
REQ-019 A granted buffered entry clears its buffer valid bit at the same edge.
REQ-020 Latency: an input accepted in cycle N with no conflict and no stall appears on out_rob_* in cycle N+1.
REQ-021 A result is delivered exactly once, with its source order preserved; there is no drop and no duplication.
REQ-022 Conflict (both candidates present on an advance): the winner is chosen by arbitration policy (REQ-029/030); the loser is retained.
REQ-023 LS-sourced output: out_rob_set_nzcv=0 and out_rob_nzcv=0.
REQ-024 ALU-sourced output: out_rob_set_nzcv and out_rob_nzcv pass through unchanged.
REQ-025 Simultaneous grant of a buffered entry and new input on the same source is impossible (ready=0 while buffer full), so no case exists for it.

Reset
REQ-026 in_rst on a clock edge clears both buffer valid bits, sets out_rob_done=0 and sets last_grant=WB_SRC_LS, so ALU wins the first conflict.
REQ-027 During reset, out_rob_index, value, set_nzcv, nzcv and src are 0, and out_X_ready is 1 from the cycle after reset.
REQ-028 Inputs presented in a reset cycle are discarded, including mid-stall, and entries held in buffers are lost.

Configuration
REQ-029 Macro FU_WB_ROUND_ROBIN_EN defined: on a conflict, grant the source not equal to last_grant; last_grant updates on every grant.
REQ-030 Macro undefined: fixed priority, with ALU always winning conflicts; the last_grant register is not built.

Structure
REQ-031 The shared package holds:
- typedef enum wb_src_t {WB_SRC_ALU, WB_SRC_LS};
- struct wb_entry_t {dst_rob_index, value, set_nzcv, nzcv}.
REQ-032 Sub-module wb_hold_buf (one-entry holding buffer: valid, entry, load, clear, ready) is instantiated once per source.
REQ-033 Arbitration and the output register live in fu_wb_arbiter itself.

Verification
REQ-034 After reset, ALU done with idx=3, val=42, set_nzcv=1, nzcv=4'b0100 -> next cycle out_rob_done=1, idx=3, val=42, nzcv=4'b0100, src=ALU.
REQ-035 ALU idx=1 val=10 and LS idx=2 val=20 in the same cycle, with round-robin -> cycle N+1 ALU idx1, N+2 LS idx2 with set_nzcv=0, out_ls_ready=0 in cycle N+1.
REQ-036 Same stimulus with FU_WB_ROUND_ROBIN_EN undefined, repeated over 3 back-to-back pairs -> ALU outputs first each pair; LS is drained only when ALU is idle.
REQ-037 in_rob_stall=1 for 4 cycles while ALU idx5 is on the output; LS idx6 arrives -> output holds idx5 for all 4 cycles, out_ls_ready=0; idx6 appears one cycle after the stall drops.
REQ-038 Both buffers full under stall, then in_rst=1 for one cycle -> next cycle out_rob_done=0, both readies=1; no stale entry is ever emitted.
REQ-039 Randomized-gap stream of 100 ALU and 100 LS results with random stalls -> each ROB index is emitted exactly once, in per-source order.
